sr_debounce_driver: RTL and testbench

Upstream stage of the cross-coupled NOR SR latch. It takes two raw, bouncing pushbuttons (set, reset). Each button is synchronised and debounced, and each press becomes a fixed-width, mutually exclusive pulse on s or r. The latch therefore never sees s=r=1 and never sees a bounce train. A small FSM serialises requests and inserts a guard gap between pulses.

---
 rtl/sr_debounce_driver_if.sv | 21 ++
 rtl/sr_debounce_driver.sv | 124 ++++++++++++
 tb/tb_sr_debounce_driver.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sr_debounce_driver_if.sv
// Button inputs and latch-drive outputs of the SR latch front end.
// The master drives the raw buttons; the slave (driver) produces the pulses.
interface sr_debounce_driver_if;
    logic btn_s;
    logic btn_r;
    logic s;
    logic r;
    logic busy;
    logic last;
    logic conflict;

    modport master (
        output btn_s, btn_r,
        input  s, r, busy, last, conflict
    );

    modport slave (
        input  btn_s, btn_r,
        output s, r, busy, last, conflict
    );
endinterface

// File: rtl/sr_debounce_driver.sv
// Debounces two raw pushbuttons and turns each press into a fixed-width,
// mutually exclusive s/r pulse for a NOR SR latch, with a guard gap between pulses.
module sr_debounce_driver #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned PULSE_W   = 2,
    parameter int unsigned CW        = 8
) (
    input logic                 clk,
    input logic                 rst,
    sr_debounce_driver_if.slave bus
);
    localparam int unsigned PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [CW-1:0]  DbLast = CW'(DB_CYCLES - 1);
    localparam logic [PCW-1:0] PwLast = PCW'(PULSE_W - 1);

    typedef enum logic [1:0] {StIdle, StPulseS, StPulseR, StGap} state_t;

    // Channel index 0 is set, 1 is reset.
    logic [1:0]    btn;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    stable_d;
    logic [CW-1:0] cnt [2];
    logic [1:0]    req;

    state_t         state;
    logic [PCW-1:0] pcnt;
    logic           pend_s;
    logic           pend_r;
    logic           s_q;
    logic           r_q;
    logic           last_q;
    logic           conflict_q;

    assign btn = {bus.btn_r, bus.btn_s};
    assign req = stable & ~stable_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DbLast) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            pcnt       <= '0;
            pend_s     <= 1'b0;
            pend_r     <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            last_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= req[0] & req[1];
            unique case (state)
                StIdle: begin
                    pcnt <= '0;
                    // Reset wins so the latch is never driven toward both states at once.
                    if (pend_r || req[1]) begin
                        state  <= StPulseR;
                        r_q    <= 1'b1;
                        pend_r <= 1'b0;
                        pend_s <= pend_s | req[0];
                    end else if (pend_s || req[0]) begin
                        state  <= StPulseS;
                        s_q    <= 1'b1;
                        pend_s <= 1'b0;
                    end
                end
                StPulseS, StPulseR: begin
                    pend_s <= pend_s | req[0];
                    pend_r <= pend_r | req[1];
                    if (pcnt == PwLast) begin
                        state  <= StGap;
                        s_q    <= 1'b0;
                        r_q    <= 1'b0;
                        last_q <= (state == StPulseS);
                        pcnt   <= '0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                StGap: begin
                    pend_s <= pend_s | req[0];
                    pend_r <= pend_r | req[1];
                    state  <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    s_q   <= 1'b0;
                    r_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.last     = last_q;
    assign bus.conflict = conflict_q;
    assign bus.busy     = (state != StIdle) | pend_s | pend_r;
endmodule

// File: tb/tb_sr_debounce_driver.sv
// Directed bench for sr_debounce_driver: stimulus queues expected pulses and
// conflict flags; a negedge monitor pops and checks them as the DUT emits them.
module tb_sr_debounce_driver;
    localparam int unsigned DB  = 4;
    localparam int unsigned PW  = 2;
    localparam int          LAT = DB + 2;

    typedef struct {
        bit is_s;
        int start;
        int width;
        bit last_v;
    } pulse_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    pulse_t exp_q[$];
    int     conf_q[$];

    sr_debounce_driver_if ifc ();

    sr_debounce_driver #(
        .DB_CYCLES (DB),
        .PULSE_W   (PW),
        .CW        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic wait_to(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic push_pulse(input bit is_s, input int start, input bit last_v);
        pulse_t p;
        p.is_s   = is_s;
        p.start  = start;
        p.width  = PW;
        p.last_v = last_v;
        exp_q.push_back(p);
    endtask

    task automatic release_all();
        ifc.btn_s = 1'b0;
        ifc.btn_r = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    // Monitor: pulse start/width/last, mutual exclusion, conflict timing.
    pulse_t cur;
    bit     in_pulse = 1'b0;
    int     width = 0;

    always @(negedge clk) begin
        checks++;
        if (ifc.s && ifc.r) begin
            errors++;
            $display("FAIL exclusive: s=1 r=1 at edge %0d", edge_n);
        end
        if (ifc.conflict) begin
            if (conf_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL conflict: unexpected flag at edge %0d", edge_n);
            end else begin
                chk("conflict_edge", edge_n, conf_q.pop_front());
            end
        end
        if (!in_pulse && (ifc.s || ifc.r)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse: unexpected s=%0d r=%0d at edge %0d", ifc.s, ifc.r, edge_n);
            end else begin
                cur = exp_q.pop_front();
                chk("pulse_chan_s", int'(ifc.s), int'(cur.is_s));
                chk("pulse_start", edge_n, cur.start);
            end
            in_pulse = 1'b1;
            width    = 1;
        end else if (in_pulse && (ifc.s || ifc.r)) begin
            width++;
        end else if (in_pulse) begin
            chk("pulse_width", width, cur.width);
            chk("last_after_pulse", int'(ifc.last), int'(cur.last_v));
            in_pulse = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        ifc.btn_s = 1'b0;
        ifc.btn_r = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_s", int'(ifc.s), 0);
        chk("rst_r", int'(ifc.r), 0);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_last", int'(ifc.last), 0);
        chk("rst_conflict", int'(ifc.conflict), 0);

        // Clean set press.
        @(negedge clk);
        ifc.btn_s = 1'b1;
        k = edge_n + 1;
        push_pulse(1'b1, k + LAT, 1'b1);
        wait_to(k + LAT + 3);
        chk("t1_busy_idle", int'(ifc.busy), 0);
        chk("t1_last", int'(ifc.last), 1);
        release_all();

        // Bouncing reset button: only the final held level produces a pulse.
        ifc.btn_r = 1'b1; @(negedge clk);
        ifc.btn_r = 1'b0; @(negedge clk);
        ifc.btn_r = 1'b1; @(negedge clk);
        ifc.btn_r = 1'b0; @(negedge clk);
        ifc.btn_r = 1'b1;
        k = edge_n + 1;
        push_pulse(1'b0, k + LAT, 1'b0);
        wait_to(k + LAT + 3);
        chk("t2_busy_idle", int'(ifc.busy), 0);
        release_all();

        // Simultaneous press: conflict, r first, then pending s.
        ifc.btn_s = 1'b1;
        ifc.btn_r = 1'b1;
        k = edge_n + 1;
        conf_q.push_back(k + LAT);
        push_pulse(1'b0, k + LAT, 1'b0);
        push_pulse(1'b1, k + LAT + 4, 1'b1);
        wait_to(k + LAT + 3);
        chk("t3_busy_pending", int'(ifc.busy), 1);
        wait_to(k + LAT + 7);
        chk("t3_busy_idle", int'(ifc.busy), 0);
        release_all();

        // Set press completes during the r pulse and waits as pending.
        ifc.btn_r = 1'b1;
        k = edge_n + 1;
        @(negedge clk);
        ifc.btn_s = 1'b1;
        push_pulse(1'b0, k + LAT, 1'b0);
        push_pulse(1'b1, k + LAT + 4, 1'b1);
        wait_to(k + LAT + 2);
        chk("t4_busy_gap", int'(ifc.busy), 1);
        wait_to(k + LAT + 3);
        chk("t4_busy_pending", int'(ifc.busy), 1);
        chk("t4_s_idle", int'(ifc.s), 0);
        release_all();

        // Button held through reset counts as a fresh press afterwards.
        rst = 1'b1;
        ifc.btn_s = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("t5_last_cleared", int'(ifc.last), 0);
        chk("t5_busy_cleared", int'(ifc.busy), 0);
        k = edge_n + 1;
        push_pulse(1'b1, k + LAT, 1'b1);
        wait_to(k + LAT + 4);
        release_all();

        // Reset in the second cycle of an s pulse.
        ifc.btn_s = 1'b1;
        k = edge_n + 1;
        push_pulse(1'b1, k + LAT, 1'b0);
        wait_to(k + LAT + 1);
        rst = 1'b1;
        ifc.btn_s = 1'b0;
        @(negedge clk);
        chk("t6_s_dropped", int'(ifc.s), 0);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", int'(ifc.busy), 0);
        chk("t6_last", int'(ifc.last), 0);
        repeat (20) @(negedge clk);

        chk("pulses_outstanding", exp_q.size(), 0);
        chk("conflicts_outstanding", conf_q.size(), 0);
        chk("pulse_open", int'(in_pulse), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
